// File: rtl/input_debouncer.sv
// input_debouncer: synchroniser plus counter-based debounce FSM producing a glitch-free clean_out.
// Optional aborted-transition counter enabled by INPUT_DEBOUNCER_GLITCH_CNT_EN.
module input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GLITCH_CNT_W    = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic noisy_in,
  input  logic enable,
  output logic clean_out,
  output logic busy
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  ,
  input  logic                    glitch_clr,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);
  localparam int CNT_W = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || GLITCH_CNT_W < 1) begin : g_bad_params
    $error("input_debouncer: illegal parameter value");
  end
  // Encoding {clean, checking}: outputs come straight off the state flops
  typedef enum logic [1:0] {
    S_LOW    = 2'b00,
    S_CHK_HI = 2'b01,
    S_HIGH   = 2'b10,
    S_CHK_LO = 2'b11
  } state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic sync_in;
  assign sync_in = sync[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync  <= '0;
      state <= S_LOW;
      cnt   <= '0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], noisy_in};
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_LOW: if (enable && sync_in) begin
        state_n = S_CHK_HI;
        cnt_n   = '0;
      end
      S_HIGH: if (enable && !sync_in) begin
        state_n = S_CHK_LO;
        cnt_n   = '0;
      end
      S_CHK_HI: if (!enable) state_n = S_LOW;
        else if (!sync_in) begin
          state_n = S_LOW;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) state_n = S_HIGH;
        else cnt_n = cnt + 1'b1;
      default: if (!enable) state_n = S_HIGH;
        else if (sync_in) begin
          state_n = S_HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) state_n = S_LOW;
        else cnt_n = cnt + 1'b1;
    endcase
  end
  always_comb begin
    clean_out = state[1];
    busy      = state[0];
  end
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  // A glitch is the input reverting to the current clean level while checking
  logic glitch;
  assign glitch = enable && state[0] && (sync_in == state[1]);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) glitch_cnt <= '0;
    else if (glitch_clr) glitch_cnt <= '0;
    else if (glitch && !(&glitch_cnt)) glitch_cnt <= glitch_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed checks of input_debouncer at defaults and at SYNC_STAGES=3, DEBOUNCE_CYCLES=1.
module tb_input_debouncer;
  logic clk = 1'b0, resetn = 1'b0, noisy_in = 1'b0, enable = 1'b1, noisy2 = 1'b0;
  logic clean_out, busy, clean2, busy2;
  int errors = 0, checks = 0;
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  logic glitch_clr = 1'b0, glitch_clr2 = 1'b0;
  logic [7:0] glitch_cnt;
  logic [1:0] glitch_cnt2;
`endif
  always #5 clk = ~clk;
  input_debouncer dut (
    .clk(clk), .resetn(resetn), .noisy_in(noisy_in), .enable(enable),
    .clean_out(clean_out), .busy(busy)
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    , .glitch_clr(glitch_clr), .glitch_cnt(glitch_cnt)
`endif
  );
  input_debouncer #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .GLITCH_CNT_W(2)) dut2 (
    .clk(clk), .resetn(resetn), .noisy_in(noisy2), .enable(1'b1),
    .clean_out(clean2), .busy(busy2)
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    , .glitch_clr(glitch_clr2), .glitch_cnt(glitch_cnt2)
`endif
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    logic e;
    resetn = 1'b0; noisy_in = 1'b1; noisy2 = 1'b0; enable = 1'b1;
    repeat (3) tick();
    checks++;
    if ({clean_out, busy, clean2, busy2} !== 4'b0000) begin
      errors++; $display("FAIL reset_state outs=%b expected 0000", {clean_out, busy, clean2, busy2});
    end
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    checks++;
    if (glitch_cnt !== 8'd0) begin errors++; $display("FAIL reset_glitch_cnt got %0d expected 0", glitch_cnt); end
`endif
    resetn = 1'b1;
    tick();
    for (int k = 1; k <= 18; k++) begin
      tick();
      e = (k >= 18);
      checks++;
      if (clean_out !== e) begin errors++; $display("FAIL reset_release_clean edge %0d got %b expected %b", k, clean_out, e); end
      e = (k >= 2 && k <= 17);
      checks++;
      if (busy !== e) begin errors++; $display("FAIL reset_release_busy edge %0d got %b expected %b", k, busy, e); end
    end
  endtask
  task automatic test_rise_fall;
    logic e;
    noisy_in = 1'b0;
    tick();
    for (int k = 1; k <= 18; k++) begin
      tick();
      e = (k < 18);
      checks++;
      if (clean_out !== e) begin errors++; $display("FAIL fall edge %0d got %b expected %b", k, clean_out, e); end
    end
    noisy_in = 1'b1;
    tick();
    for (int k = 1; k <= 18; k++) begin
      tick();
      e = (k >= 18);
      checks++;
      if (clean_out !== e) begin errors++; $display("FAIL rise edge %0d got %b expected %b", k, clean_out, e); end
    end
    noisy_in = 1'b0;
    repeat (19) tick();
    checks++;
    if (clean_out !== 1'b0) begin errors++; $display("FAIL fall2 got %b expected 0", clean_out); end
  endtask
  task automatic test_bounce;
    int w[4] = '{1, 3, 5, 15};
    logic seen;
    for (int i = 0; i < 4; i++) begin
      seen = 1'b0;
      noisy_in = 1'b1;
      repeat (w[i]) begin tick(); seen |= clean_out; end
      noisy_in = 1'b0;
      repeat (20) begin tick(); seen |= clean_out; end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL bounce width %0d clean_out rose, expected stay 0", w[i]); end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bounce_busy got %b expected 0", busy); end
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    checks++;
    if (glitch_cnt !== 8'd4) begin errors++; $display("FAIL bounce_glitch_cnt got %0d expected 4", glitch_cnt); end
`endif
  endtask
  task automatic test_enable;
    logic e;
    noisy_in = 1'b1;
    tick();
    repeat (9) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL enable_pre_busy got %b expected 1", busy); end
    enable = 1'b0;
    tick();
    checks++;
    if ({busy, clean_out} !== 2'b00) begin errors++; $display("FAIL enable_abort busy,clean=%b expected 00", {busy, clean_out}); end
    repeat (20) tick();
    checks++;
    if ({busy, clean_out} !== 2'b00) begin errors++; $display("FAIL enable_hold_low busy,clean=%b expected 00", {busy, clean_out}); end
    enable = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      e = (k >= 17);
      checks++;
      if (clean_out !== e) begin errors++; $display("FAIL enable_recount edge %0d got %b expected %b", k, clean_out, e); end
    end
    enable = 1'b0; noisy_in = 1'b0;
    repeat (30) tick();
    checks++;
    if ({busy, clean_out} !== 2'b01) begin errors++; $display("FAIL enable_freeze_high busy,clean=%b expected 01", {busy, clean_out}); end
    enable = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      e = (k < 17);
      checks++;
      if (clean_out !== e) begin errors++; $display("FAIL enable_fall edge %0d got %b expected %b", k, clean_out, e); end
    end
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    checks++;
    if (glitch_cnt !== 8'd4) begin errors++; $display("FAIL enable_not_glitch got %0d expected 4", glitch_cnt); end
`endif
  endtask
  task automatic test_reset_mid;
    logic e;
    noisy_in = 1'b1;
    repeat (8) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_mid_pre busy got %b expected 1", busy); end
    resetn = 1'b0;
    #1;
    checks++;
    if ({busy, clean_out} !== 2'b00) begin errors++; $display("FAIL reset_mid_async busy,clean=%b expected 00", {busy, clean_out}); end
    tick();
    resetn = 1'b1;
    tick();
    for (int k = 1; k <= 18; k++) begin
      tick();
      e = (k >= 18);
      checks++;
      if (clean_out !== e) begin errors++; $display("FAIL reset_mid_release edge %0d got %b expected %b", k, clean_out, e); end
    end
    noisy_in = 1'b0;
    repeat (20) tick();
  endtask
  task automatic test_fast;
    logic e;
    noisy2 = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      e = (k >= 4);
      checks++;
      if (clean2 !== e) begin errors++; $display("FAIL fast_rise edge %0d got %b expected %b", k, clean2, e); end
    end
    noisy2 = 1'b0;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      e = (k < 4);
      checks++;
      if (clean2 !== e) begin errors++; $display("FAIL fast_fall edge %0d got %b expected %b", k, clean2, e); end
    end
    repeat (4) tick();
    noisy2 = 1'b1;
    tick();
    tick();
    noisy2 = 1'b0;
    tick();
    tick();
    checks++;
    if (clean2 !== 1'b0) begin errors++; $display("FAIL fast_pulse_e3 got %b expected 0", clean2); end
    tick();
    checks++;
    if (clean2 !== 1'b1) begin errors++; $display("FAIL fast_pulse_e4 got %b expected 1", clean2); end
    repeat (6) tick();
    checks++;
    if (clean2 !== 1'b0) begin errors++; $display("FAIL fast_pulse_back got %b expected 0", clean2); end
  endtask
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  task automatic test_glitch_sat;
    glitch_clr2 = 1'b1;
    tick();
    glitch_clr2 = 1'b0;
    checks++;
    if (glitch_cnt2 !== 2'd0) begin errors++; $display("FAIL glitch_clear got %0d expected 0", glitch_cnt2); end
    repeat (5) begin
      noisy2 = 1'b1;
      tick();
      noisy2 = 1'b0;
      repeat (6) tick();
    end
    checks++;
    if (glitch_cnt2 !== 2'd3) begin errors++; $display("FAIL glitch_saturate got %0d expected 3", glitch_cnt2); end
    checks++;
    if (clean2 !== 1'b0) begin errors++; $display("FAIL glitch_clean got %b expected 0", clean2); end
    noisy2 = 1'b1;
    tick();
    noisy2 = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy2 !== 1'b1) begin errors++; $display("FAIL glitch_pending busy got %b expected 1", busy2); end
    glitch_clr2 = 1'b1;
    tick();
    glitch_clr2 = 1'b0;
    checks++;
    if ({busy2, glitch_cnt2} !== 3'b000) begin errors++; $display("FAIL glitch_clr_priority busy,cnt=%b expected 000", {busy2, glitch_cnt2}); end
  endtask
`endif
  initial begin
    test_reset();
    test_rise_fall();
    test_bounce();
    test_enable();
    test_reset_mid();
    test_fast();
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    test_glitch_sat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
